// File: rtl/flow_stats_pkg.sv
// -----------------------------------------------------------------------------
// flow_stats_pkg
// Shared definitions for the per-window flow statistics engine:
//   - field widths of a flow-table entry and the saturation value of its count
//   - flow_entry_t : one table entry {ts, cnt}; cnt == 0 marks an empty entry
//   - flow_state_t : INIT (table clearing) / RUN (packet processing)
//   - entry_live() : age test deciding whether an entry still belongs to a
//                    window that started at most `limit` cycles ago
// -----------------------------------------------------------------------------
package flow_stats_pkg;

  localparam int unsigned FLOW_TS_WIDTH  = 40;
  localparam int unsigned FLOW_CNT_WIDTH = 4;

  typedef logic [FLOW_TS_WIDTH-1:0]  flow_ts_t;
  typedef logic [FLOW_CNT_WIDTH-1:0] flow_cnt_t;

  // Per-entry packet count saturates here instead of wrapping back to "empty".
  localparam flow_cnt_t CNT_SAT = '1;

  typedef struct packed {
    flow_ts_t  ts;
    flow_cnt_t cnt;
  } flow_entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } flow_state_t;

  // Age is taken modulo 2^TS_WIDTH so the free-running timestamp may wrap.
  function automatic logic entry_live(flow_entry_t e, flow_ts_t now, flow_ts_t limit);
    flow_ts_t age;
    age = now - e.ts;
    return (e.cnt != '0) && (age <= limit);
  endfunction

endpackage

// File: rtl/flow_win_ram.sv
// -----------------------------------------------------------------------------
// flow_win_ram
// Simple dual-port, read-first RAM with one cycle of read latency. A read and
// a write to the same address in one cycle return the old contents.
// Ports:
//   asclk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (sampled every cycle)
//   o_rdata  read data, valid the cycle after i_raddr is presented
// -----------------------------------------------------------------------------
module flow_win_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 44
) (
  input  logic                  asclk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // NOTE: the array has no reset so it maps onto block RAM; the owner clears
  // it by writing every address after reset.
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge asclk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/flow_window_stats.sv
// -----------------------------------------------------------------------------
// flow_window_stats
// Per-window flow statistics. Packets are hashed into one timestamped table;
// an entry counts as part of the current window when its age does not exceed
// the cycles elapsed in the window, so no table swap or bulk clear is needed.
// Optional feature macro: FLOW_WIN_CONT_EN (continuing-flow counter).
// TS_WIDTH / CNT_PKT_WIDTH must match the entry record in flow_stats_pkg.
// Ports:
//   asclk, aresetn   clock, synchronous active-low reset
//   pkt_valid        packet present this cycle (no backpressure)
//   pkt_port         source port; accepted only when < NUM_PORTS
//   addr_hash        flow hash / table index
//   num_flow         distinct flows in the last completed window
//   num_flow_small   flows with count <= SMALL_THRESH in that window
//   num_flow_cont    flows also seen in the window before (0 without macro)
//   stats_valid      one-cycle pulse when the statistics update
//   init_busy        table initialisation in progress
// -----------------------------------------------------------------------------
module flow_window_stats
  import flow_stats_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH    = 10,
  parameter int unsigned TS_WIDTH       = FLOW_TS_WIDTH,
  parameter int unsigned CNT_PKT_WIDTH  = FLOW_CNT_WIDTH,
  parameter int unsigned NUM_FLOW_WIDTH = 32,
  parameter int unsigned WINDOW_CYCLES  = 160000000,
  parameter int unsigned SMALL_THRESH   = 1,
  parameter int unsigned NUM_PORTS      = 4
) (
  input  logic                      asclk,
  input  logic                      aresetn,
  input  logic                      pkt_valid,
  input  logic [2:0]                pkt_port,
  input  logic [DEPTH_WIDTH-1:0]    addr_hash,
  output logic [NUM_FLOW_WIDTH-1:0] num_flow,
  output logic [NUM_FLOW_WIDTH-1:0] num_flow_small,
  output logic [NUM_FLOW_WIDTH-1:0] num_flow_cont,
  output logic                      stats_valid,
  output logic                      init_busy
);

  localparam int unsigned       ENTRY_W   = TS_WIDTH + CNT_PKT_WIDTH;
  localparam int unsigned       WIN_W     = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam flow_cnt_t         SMALL_CNT = flow_cnt_t'(SMALL_THRESH);

  typedef logic [NUM_FLOW_WIDTH-1:0] stat_t;

  // ---------------------------------------------------------------- FSM
  flow_state_t            r_state;
  flow_state_t            w_state_next;
  logic [DEPTH_WIDTH-1:0] r_init_addr;
  logic                   w_run;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && r_init_addr == '1) begin
      w_state_next = ST_RUN;
    end
  end

  always_comb begin
    init_busy = (r_state == ST_INIT);
    w_run     = (r_state == ST_RUN);
  end

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= r_init_addr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- window timing
  logic [WIN_W-1:0] r_win_cnt;
  flow_ts_t         r_now;
  logic             w_boundary;

  assign w_boundary = w_run && (r_win_cnt == WIN_LAST);

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      r_win_cnt <= '0;
      r_now     <= '0;
    end else if (w_run) begin
      r_now     <= r_now + 1'b1;
      r_win_cnt <= w_boundary ? '0 : r_win_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- pipeline
  logic                   w_accept;
  logic                   r_s1_valid;
  logic [DEPTH_WIDTH-1:0] r_s1_addr;
  logic                   r_w1_valid, r_w2_valid;
  logic [DEPTH_WIDTH-1:0] r_w1_addr,  r_w2_addr;
  flow_entry_t            r_w1_data,  r_w2_data;

  assign w_accept = pkt_valid && w_run && (32'(pkt_port) < NUM_PORTS);

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      r_s1_valid <= 1'b0;
      r_w1_valid <= 1'b0;
      r_w2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_w1_valid <= r_s1_valid;
      r_w2_valid <= r_w1_valid;
    end
  end

  // ---------------------------------------------------------------- table RAM
  logic [ENTRY_W-1:0]     w_ram_rdata;
  logic                   w_ram_we;
  logic [DEPTH_WIDTH-1:0] w_ram_waddr;
  logic [ENTRY_W-1:0]     w_ram_wdata;

  assign w_ram_we    = init_busy || r_w1_valid;
  assign w_ram_waddr = init_busy ? r_init_addr : r_w1_addr;
  assign w_ram_wdata = init_busy ? '0 : r_w1_data;

  flow_win_ram #(
    .ADDR_WIDTH (DEPTH_WIDTH),
    .DATA_WIDTH (ENTRY_W)
  ) u_ram (
    .asclk   (asclk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (addr_hash),
    .o_rdata (w_ram_rdata)
  );

  // ---------------------------------------------------------------- compute
  // w1 is being written this cycle; w2 was written on the same edge that
  // sampled our read address, which read-first RAM does not reflect.
  flow_entry_t w_entry;
  logic        w_hit;
  flow_cnt_t   w_cnt_new;

  always_comb begin
    w_entry = flow_entry_t'(w_ram_rdata);
    if (r_w2_valid && r_w2_addr == r_s1_addr) w_entry = r_w2_data;
    if (r_w1_valid && r_w1_addr == r_s1_addr) w_entry = r_w1_data;  // newest wins
    w_hit = entry_live(w_entry, r_now, flow_ts_t'(r_win_cnt));
    if (!w_hit)                      w_cnt_new = flow_cnt_t'(1);
    else if (w_entry.cnt == CNT_SAT) w_cnt_new = CNT_SAT;
    else                             w_cnt_new = w_entry.cnt + 1'b1;
  end

  // Write-stage payload is qualified by the valids, so it carries no reset.
  always_ff @(posedge asclk) begin
    r_w1_addr <= r_s1_addr;
    r_w1_data <= '{ts: r_now, cnt: w_cnt_new};
    r_w2_addr <= r_w1_addr;
    r_w2_data <= r_w1_data;
    r_s1_addr <= addr_hash;
  end

  // ---------------------------------------------------------------- counters
  stat_t r_flow, r_small, w_flow_next, w_small_next;
  stat_t r_num_flow, r_num_small;
  logic  r_stats_valid;

  always_comb begin
    w_flow_next  = r_flow;
    w_small_next = r_small;
    if (r_s1_valid) begin
      if (w_hit) begin
        if (w_entry.cnt == SMALL_CNT) w_small_next = r_small - 1'b1;
      end else begin
        w_flow_next  = r_flow + 1'b1;
        w_small_next = r_small + 1'b1;
      end
    end
  end

  // At the boundary the outputs take the next-state values so a packet
  // computed in the last cycle still lands in the closing window.
  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      r_flow        <= '0;
      r_small       <= '0;
      r_num_flow    <= '0;
      r_num_small   <= '0;
      r_stats_valid <= 1'b0;
    end else begin
      r_stats_valid <= w_boundary;
      if (w_boundary) begin
        r_flow      <= '0;
        r_small     <= '0;
        r_num_flow  <= w_flow_next;
        r_num_small <= w_small_next;
      end else begin
        r_flow  <= w_flow_next;
        r_small <= w_small_next;
      end
    end
  end

  assign num_flow       = r_num_flow;
  assign num_flow_small = r_num_small;
  assign stats_valid    = r_stats_valid;

`ifdef FLOW_WIN_CONT_EN
  // A miss on an entry still inside the previous window is a flow that
  // carried over the boundary.
  localparam flow_ts_t WIN_LEN_TS = flow_ts_t'(WINDOW_CYCLES);

  stat_t r_cont, r_num_cont, w_cont_next;
  logic  w_cont_live;

  assign w_cont_live = entry_live(w_entry, r_now, flow_ts_t'(r_win_cnt) + WIN_LEN_TS);

  always_comb begin
    w_cont_next = r_cont;
    if (r_s1_valid && !w_hit && w_cont_live) w_cont_next = r_cont + 1'b1;
  end

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      r_cont     <= '0;
      r_num_cont <= '0;
    end else if (w_boundary) begin
      r_cont     <= '0;
      r_num_cont <= w_cont_next;
    end else begin
      r_cont <= w_cont_next;
    end
  end

  assign num_flow_cont = r_num_cont;
`else
  assign num_flow_cont = '0;
`endif

endmodule

// File: doc/flow_window_stats.md
# flow_window_stats

Per-window flow statistics engine for the OpenFlow datapath. It hashes each packet from a physical port into a single timestamped flow table. For every fixed-length measurement window it reports the number of distinct flows, the number of small flows (at most SMALL_THRESH packets) and, optionally, the number of flows continuing from the previous window. It replaces ping-pong table swapping and bulk table clearing with timestamp-age validity, so no packets are lost at window boundaries.

## Interface
Parameters:
- DEPTH_WIDTH, 10: table has 2^DEPTH_WIDTH entries, indexed by addr_hash.
- TS_WIDTH, 40: free-running timestamp width.
- CNT_PKT_WIDTH, 4: per-entry packet counter width, saturating.
- NUM_FLOW_WIDTH, 32: width of the statistics outputs.
- WINDOW_CYCLES, 160000000: window length in asclk cycles, at least 2^DEPTH_WIDTH + 4.
- SMALL_THRESH, 1: a flow is small while its count is at most this value; range 1 to 2^CNT_PKT_WIDTH-2.
- NUM_PORTS, 4: a packet is accepted only if pkt_port < NUM_PORTS.

Ports:
- asclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  one packet per cycle; there is no backpressure.
- pkt_port  in  3  source port of the packet.
- addr_hash  in  DEPTH_WIDTH  flow hash.
- num_flow  out  NUM_FLOW_WIDTH  distinct flows in the last completed window.
- num_flow_small  out  NUM_FLOW_WIDTH  small flows in the last completed window.
- num_flow_cont  out  NUM_FLOW_WIDTH  continuing flows; tied to 0 without the macro.
- stats_valid  out  1  one-cycle pulse when the outputs update.
- init_busy  out  1  table initialisation in progress.

## Operation
- Each table entry is {ts[TS_WIDTH], cnt[CNT_PKT_WIDTH]}. cnt = 0 means empty.
- FSM states:
  - INIT: entered from reset. Writes zeros to entries 0 through 2^DEPTH_WIDTH-1, one per cycle. Packets are dropped. Moves to RUN after the last entry is written.
  - RUN: packets are processed.
- Windows:
  - win_cnt counts from 0 to WINDOW_CYCLES-1 and holds at 0 during INIT.
  - now is a TS_WIDTH counter that increments every RUN cycle and wraps modulo 2^TS_WIDTH.
- Per packet, in the compute stage, with entry e after forwarding: age = (now - e.ts) mod 2^TS_WIDTH.
- Hit (e.cnt != 0 and age <= win_cnt):
  - cnt' = min(e.cnt+1, 2^CNT_PKT_WIDTH-1).
  - If e.cnt == SMALL_THRESH, decrement the small counter.
- Miss (anything else):
  - cnt' = 1.
  - Increment the flow counter and the small counter.
  - If the macro is enabled, e.cnt != 0 and age <= win_cnt + WINDOW_CYCLES, increment the continuing-flow counter.
- Write-back: {now, cnt'} is written to addr_hash.
- Hash collisions merge flows. This is accepted behaviour.
- Window boundary (cycle B, where win_cnt == WINDOW_CYCLES-1):
  - Outputs capture the counters' next-state values, including any packet computed in B.
  - The counters restart from 0 at the same edge.
  - stats_valid pulses in cycle B+1.
- Known limitation: an entry left idle for a multiple of 2^TS_WIDTH cycles can alias to valid.

## Timing
- Pipeline:
  - Cycle t: packet accepted and RAM read issued.
  - Cycle t+1: RAM data available, compute, counters updated at the end of t+1, write registers loaded.
  - Cycle t+2: RAM write.
- Throughput: one packet per cycle.
- The RAM is read-first. Hazards are removed by forwarding in the compute stage, comparing against the two newer pending writes with the same address; the newer write wins.
  - Back-to-back packets to the same hash (t, t+1) produce cnt 1 then 2.
  - Packets at t and t+2 are also forwarded.
- Reset values: all outputs 0 and stats_valid 0; the pipeline valids are cleared.
  - init_busy is 1 from the first cycle after reset through the final INIT write.
  - Reset asserted during RUN or INIT flushes the pipeline and restarts INIT from address 0.
- A packet accepted during the last INIT cycle is dropped. The first counted packet is the one accepted in the first cycle after init_busy falls.

## Configuration
- FLOW_WIN_CONT_EN defined: the continuing-flow counter, the extended-age comparator and the num_flow_cont output logic are built.
- Undefined: num_flow_cont is constant 0, and no counter or comparator logic is instantiated.

## Structure
- Shared package (flow_stats_pkg) holds:
  - the entry record typedef {ts, cnt};
  - the age/hit function;
  - the count saturation constant.
- One sub-module, flow_win_ram: an inferred simple dual-port, read-first RAM with 1-cycle read latency and width TS_WIDTH+CNT_PKT_WIDTH.
- The FSM, pipeline, forwarding and counters stay in the top module.

## Test plan
- Reset: after deassertion, init_busy stays high for 1024 cycles and outputs are 0. Packets sent during INIT produce num_flow = 0 at the first boundary.
- Flow counts: with WINDOW_CYCLES=2000, send 5 hashes once each and hash 7 three times. Expect num_flow=6 and num_flow_small=5 with a single stats_valid pulse.
- Forwarding: send hash 3 in 4 consecutive cycles, then at t and t+2. The entry count reaches 6, and num_flow=1, num_flow_small=0.
- Window boundary: a packet whose compute cycle is B is counted in the closing window. A same-hash packet one cycle later is a miss in the new window (num_flow=1 in each window).
- Continuing flows (macro enabled): hash 9 is sent in window N and again in window N+1, giving num_flow_cont=1. A hash idle for a full window between packets gives 0. Without the macro, num_flow_cont stays 0.
- Saturation and port filter: 20 packets to one hash leave cnt at 15. A packet with pkt_port=5 changes no counter.
